sobel_result_collector: RTL and testbench



---
 rtl/sobel_pkg.sv | 19 +
 rtl/p2p_chan_reg.sv | 41 ++++
 rtl/sobel_result_collector.sv | 142 ++++++++++++++
 tb/tb_sobel_result_collector.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel output path: default channel width, joined pixel
// and the collector state encoding.
package sobel_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] r;
    logic [DEF_DATA_W-1:0] g;
    logic [DEF_DATA_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } coll_state_e;

endpackage

// File: rtl/p2p_chan_reg.sv
// One-entry vld/busy receive register with full flag. Draining and refilling
// in the same cycle is allowed, so a channel can sustain one word per cycle.
module p2p_chan_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_drain,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_xfer;

  // Busy drops in the drain cycle, giving a combinational stall-to-busy path.
  assign o_busy = ~i_run | (r_full & ~i_drain);
  assign w_xfer = i_vld & ~o_busy;
  assign o_full = r_full;
  assign o_data = r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_xfer) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (i_drain) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sobel_result_collector.sv
// Joins the R/G/B filter result streams into 24-bit pixels and writes one
// frame to a linear-addressed frame buffer per i_start.
module sobel_result_collector
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_r_vld,
  input  logic [DATA_W-1:0]   i_r_data,
  output logic                o_r_busy,
  input  logic                i_g_vld,
  input  logic [DATA_W-1:0]   i_g_data,
  output logic                o_g_busy,
  input  logic                i_b_vld,
  input  logic [DATA_W-1:0]   i_b_data,
  output logic                o_b_busy,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [3*DATA_W-1:0] o_wr_data,
  input  logic                i_wr_busy,
  output logic                o_frame_done,
  output logic [15:0]         o_frame_cnt
);

  localparam int unsigned       NPIX     = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  coll_state_e       r_state, w_state_d;
  logic [ADDR_W-1:0] r_pix_cnt, w_pix_cnt_d;
  logic [15:0]       r_frame_cnt, w_frame_cnt_d;
  logic [1:0]        r_rst_sync;
  logic              w_rst;
  logic              w_run, w_all_full, w_wr_en, w_fire, w_last;
  logic              w_r_full, w_g_full, w_b_full;
  logic [DATA_W-1:0] w_r_data, w_g_data, w_b_data;

  // Assert asynchronously, release two clocks later on a clean edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end
  assign w_rst = r_rst_sync[1];

  assign w_run      = (r_state == RUN);
  assign w_all_full = w_r_full & w_g_full & w_b_full;
  assign w_wr_en    = w_run & w_all_full;
  assign w_fire     = w_wr_en & ~i_wr_busy;
  assign w_last     = (r_pix_cnt == LAST_PIX);

  p2p_chan_reg #(.DATA_W(DATA_W)) u_chan_r (
    .i_clk   (i_clk),
    .i_rst   (w_rst),
    .i_run   (w_run),
    .i_drain (w_fire),
    .i_vld   (i_r_vld),
    .i_data  (i_r_data),
    .o_busy  (o_r_busy),
    .o_full  (w_r_full),
    .o_data  (w_r_data)
  );

  p2p_chan_reg #(.DATA_W(DATA_W)) u_chan_g (
    .i_clk   (i_clk),
    .i_rst   (w_rst),
    .i_run   (w_run),
    .i_drain (w_fire),
    .i_vld   (i_g_vld),
    .i_data  (i_g_data),
    .o_busy  (o_g_busy),
    .o_full  (w_g_full),
    .o_data  (w_g_data)
  );

  p2p_chan_reg #(.DATA_W(DATA_W)) u_chan_b (
    .i_clk   (i_clk),
    .i_rst   (w_rst),
    .i_run   (w_run),
    .i_drain (w_fire),
    .i_vld   (i_b_vld),
    .i_data  (i_b_data),
    .o_busy  (o_b_busy),
    .o_full  (w_b_full),
    .o_data  (w_b_data)
  );

  always_comb begin
    w_state_d     = r_state;
    w_pix_cnt_d   = r_pix_cnt;
    w_frame_cnt_d = r_frame_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_d   = RUN;
          w_pix_cnt_d = '0;
        end
      end
      RUN: begin
        if (w_fire) begin
          if (w_last) begin
            w_pix_cnt_d = '0;
            w_state_d   = DONE;
          end else begin
            w_pix_cnt_d = r_pix_cnt + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        w_state_d     = IDLE;
        w_frame_cnt_d = r_frame_cnt + 16'd1;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pix_cnt   <= w_pix_cnt_d;
      r_frame_cnt <= w_frame_cnt_d;
    end
  end

  assign o_wr_en      = w_wr_en;
  assign o_wr_addr    = r_pix_cnt;
  assign o_wr_data    = {w_r_data, w_g_data, w_b_data};
  assign o_frame_done = (r_state == DONE);
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sobel_result_collector.sv
// Scoreboard bench for sobel_result_collector on a 4x2 frame: directed pixels
// are queued as expected writes and a negedge monitor checks each completed write.
module tb_sobel_result_collector;
  import sobel_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          i_rst, i_start;
  logic          i_r_vld, i_g_vld, i_b_vld;
  logic [DW-1:0] i_r_data, i_g_data, i_b_data;
  logic          o_r_busy, o_g_busy, o_b_busy;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [23:0]   o_wr_data;
  logic          i_wr_busy;
  logic          o_frame_done;
  logic [15:0]   o_frame_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    rgb_t          pix;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  logic done_exp = 1'b0;

  sobel_result_collector #(
    .DATA_W (DW),
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_r_vld      (i_r_vld),
    .i_r_data     (i_r_data),
    .o_r_busy     (o_r_busy),
    .i_g_vld      (i_g_vld),
    .i_g_data     (i_g_data),
    .o_g_busy     (o_g_busy),
    .i_b_vld      (i_b_vld),
    .i_b_data     (i_b_data),
    .o_b_busy     (o_b_busy),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .i_wr_busy    (i_wr_busy),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    logic wrote_last;
    wrote_last = 1'b0;
    if (o_wr_en && !i_wr_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 o_wr_addr, o_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(e.addr));
        chk("wr_data", 32'(o_wr_data), 32'(e.pix));
        wr_cyc_q.push_back(cyc);
        wrote_last = (e.addr == AW'(W * H - 1));
      end
    end
    if (o_frame_done || done_exp) chk("frame_done", 32'(o_frame_done), 32'(done_exp));
    if (o_frame_done) done_cnt++;
    done_exp = wrote_last;
  end

  function automatic rgb_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    rgb_t p;
    p.r = r;
    p.g = g;
    p.b = b;
    return p;
  endfunction

  task automatic push(input int addr, input rgb_t p);
    wr_t e;
    e.addr = AW'(addr);
    e.pix  = p;
    exp_q.push_back(e);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic start_frame();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Offer one pixel on all channels; each channel drops vld once it has transferred.
  task automatic send_pix(input rgb_t p);
    logic [2:0] pend, xfer;
    int n;
    pend = 3'b111;
    n = 0;
    i_r_data = p.r; i_g_data = p.g; i_b_data = p.b;
    {i_r_vld, i_g_vld, i_b_vld} = pend;
    while (pend != 3'b000 && n < 50) begin
      @(negedge clk);
      xfer = pend & ~{o_r_busy, o_g_busy, o_b_busy};
      @(posedge clk); #1;
      pend = pend & ~xfer;
      {i_r_vld, i_g_vld, i_b_vld} = pend;
      n++;
    end
    if (pend != 3'b000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got pending %b expected 000", pend);
      {i_r_vld, i_g_vld, i_b_vld} = 3'b000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_wr_busy = 1'b0;
    {i_r_vld, i_g_vld, i_b_vld} = 3'b000;
    i_r_data = '0; i_g_data = '0; i_b_data = '0;
    #1 i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("rst_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_addr", 32'(o_wr_addr), 0);
    chk("rst_data", 32'(o_wr_data), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    chk("rst_cnt", 32'(o_frame_cnt), 0);

    // Valid data offered while idle must be refused.
    i_r_data = 8'h77; i_g_data = 8'h88; i_b_data = 8'h99;
    {i_r_vld, i_g_vld, i_b_vld} = 3'b111;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
      chk("idle_wr_en", 32'(o_wr_en), 0);
    end
    @(posedge clk); #1;
    {i_r_vld, i_g_vld, i_b_vld} = 3'b000;

    // Aligned pixel, written the cycle after capture.
    start_frame();
    push(0, mk(8'h12, 8'h34, 8'h56));
    send_pix(mk(8'h12, 8'h34, 8'h56));
    chk("t1_wr_en", 32'(o_wr_en), 1);
    chk("t1_addr", 32'(o_wr_addr), 0);
    chk("t1_data", 32'(o_wr_data), 32'h123456);
    @(posedge clk); #1;

    // Skewed arrival: R at t0, G at t3, B at t5, write at t6.
    push(1, mk(8'haa, 8'hbb, 8'hcc));
    i_r_data = 8'haa; i_g_data = 8'hbb; i_b_data = 8'hcc;
    for (int k = 0; k <= 6; k++) begin
      i_r_vld = (k == 0);
      i_g_vld = (k == 3);
      i_b_vld = (k == 5);
      @(negedge clk);
      chk("t2_r_busy", 32'(o_r_busy), 32'(k >= 1 && k <= 5));
      chk("t2_g_busy", 32'(o_g_busy), 32'(k >= 4 && k <= 5));
      chk("t2_b_busy", 32'(o_b_busy), 0);
      chk("t2_wr_en", 32'(o_wr_en), 32'(k == 6));
      @(posedge clk); #1;
    end
    {i_r_vld, i_g_vld, i_b_vld} = 3'b000;

    // Stalled write holds address/data and busy until the stall drops.
    i_wr_busy = 1'b1;
    push(2, mk(8'h01, 8'h02, 8'h03));
    send_pix(mk(8'h01, 8'h02, 8'h03));
    repeat (4) begin
      @(negedge clk);
      chk("t3_wr_en", 32'(o_wr_en), 1);
      chk("t3_addr", 32'(o_wr_addr), 2);
      chk("t3_data", 32'(o_wr_data), 32'h010203);
      chk("t3_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
      @(posedge clk); #1;
    end
    i_wr_busy = 1'b0;
    @(negedge clk);
    chk("t3_release_wr_en", 32'(o_wr_en), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_after_wr_en", 32'(o_wr_en), 0);
    @(posedge clk); #1;

    // Asynchronous reset with a stalled pixel pending at address 3.
    i_wr_busy = 1'b1;
    send_pix(mk(8'hde, 8'had, 8'hbe));
    chk("t6_pending", 32'(o_wr_en), 1);
    #3 i_rst = 1'b1;
    #1;
    chk("t6_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
    chk("t6_wr_en", 32'(o_wr_en), 0);
    chk("t6_addr", 32'(o_wr_addr), 0);
    chk("t6_data", 32'(o_wr_data), 0);
    chk("t6_done", 32'(o_frame_done), 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_wr_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_post_wr_en", 32'(o_wr_en), 0);
    chk("t6_post_cnt", 32'(o_frame_cnt), 0);

    // Full frame back-to-back from address 0.
    wr_cyc_q.delete();
    start_frame();
    for (int i = 0; i < 8; i++) begin
      push(i, mk(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)));
      send_pix(mk(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t4_writes", 32'(wr_cyc_q.size()), 8);
    if (wr_cyc_q.size() == 8) chk("t4_span", 32'(wr_cyc_q[7] - wr_cyc_q[0]), 7);
    chk("t4_done_pulses", 32'(done_cnt), 1);
    chk("t4_frame_cnt", 32'(o_frame_cnt), 1);
    chk("t4_idle_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
    chk("t4_idle_wr_en", 32'(o_wr_en), 0);

    // Data held on the channels in idle is accepted once the frame starts.
    i_r_data = 8'h77; i_g_data = 8'h88; i_b_data = 8'h99;
    {i_r_vld, i_g_vld, i_b_vld} = 3'b111;
    @(negedge clk);
    chk("t5_idle_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b111);
    @(posedge clk); #1;
    push(0, mk(8'h77, 8'h88, 8'h99));
    start_frame();
    @(negedge clk);
    chk("t5_run_busy", 32'({o_r_busy, o_g_busy, o_b_busy}), 32'b000);
    @(posedge clk); #1;
    {i_r_vld, i_g_vld, i_b_vld} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
